tick_strobe_gen: RTL and testbench
==================================

Name: tick_strobe_gen

Overview:
- Upstream pacing stage for the Kami-generated counter on the icestick board.
- Divides the board clock by a programmable ratio and presents the result as a one-cycle method-enable strobe for the counter's count_value method.
- Obeys the method's RDY/EN handshake: a request that is not yet accepted stays pending, and any tick lost while pending is counted.
- Replaces the free-running slowdown register used in the top level, so the counter can run in the board clock domain.

Parameters:
- DIV_W, 21, width of the prescaler counter and of div_max.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- CLK  input  1  board clock (after global buffer); all state on posedge.
- RST_N  input  1  asynchronous active-low reset.
- run  input  1  1 = prescaler counts; 0 = prescaler frozen.
- div_max  input  DIV_W  terminal count; tick period = div_max+1 CLK cycles.
- rdy_in  input  1  consumer method ready (RDY_count_value).
- en_out  output  1  method enable to consumer (EN_count_value).
- tick  output  1  registered raw prescaler tick, one cycle wide.
- pending  output  1  a request is waiting for rdy_in.
- overrun_cnt  output  OVR_W  saturating count of ticks dropped while pending.

Behaviour:
- Reset (async assert, sync release): prescaler cnt=0, tick=0, pend=0, overrun_cnt=0. With pend=0, en_out=0 during reset.
- Prescaler:
  - When run=1 and cnt>=div_max: cnt<=0 and tick<=1 on the next edge.
  - When run=1 otherwise: cnt<=cnt+1 and tick<=0.
  - When run=0: cnt holds and tick<=0.
- Compare is >=, so lowering div_max below cnt mid-period gives a tick on the next cycle rather than a 2^DIV_W wrap.
- div_max=0 with run=1: tick=1 every cycle.
- Handshake:
  - en_out = pend & rdy_in. This is combinational, so en_out is never asserted without rdy_in in the same cycle.
  - fire = en_out.
- FSM (state reported on pend and run):
  - IDLE: pend=0, run=0. Goes to ARMED when run=1.
  - ARMED: pend=0, counting. Goes to PENDING on tick=1. Goes to IDLE on run=0.
  - PENDING: pend=1. Goes to ARMED on fire with tick=0. Stays in PENDING on fire with tick=1 (the new request is taken).
- PENDING without fire and tick=1: stay in PENDING and increment overrun_cnt, saturating at all-ones (no wrap).
- run=0 while PENDING: the request is still delivered when rdy_in rises, and no new ticks are produced.
- Latency: tick is high the cycle after the terminal count. en_out can be high that same cycle if rdy_in=1.
- Reset mid-operation clears a pending request without firing it.
- overrun_cnt is cleared only by reset.

Optional Feature:
- Macro: TICK_STEP_BTN_EN.
- When defined:
  - Adds input btn_step (async pushbutton, active-high).
  - btn_step goes through a 2-flop synchronizer, then a 16-cycle stable-level debounce filter, reset to 0.
  - A debounced rising edge injects one request exactly like a tick (same PENDING and overrun rules), independent of run.
  - A step and a tick on the same cycle count as one request.
- When undefined: btn_step port and its logic are absent; behaviour is exactly as above.

Test Plan:
- Reset then run=1, div_max=3, rdy_in=1 → tick and en_out high on cycles 4, 8, 12 after release; pending never high across consecutive cycles; overrun_cnt=0.
- div_max=0, run=1, rdy_in=1 for 10 cycles → en_out high all 10 cycles (10 fires).
- div_max=2, rdy_in=0 for 20 cycles → pending=1 after the first tick; overrun_cnt increments once per subsequent tick, reaching 5 at cycle 18. Raise rdy_in → exactly one en_out pulse, then pending=0.
- OVR_W=8, rdy_in=0, div_max=0 for 300 cycles → overrun_cnt saturates at 255 and holds.
- cnt=10 with div_max=20, switch div_max to 4 → tick on the next cycle, then period 5. Separately, run=0 while PENDING → request fires when rdy_in=1 and no further ticks follow.
- With TICK_STEP_BTN_EN defined: run=0, bounce btn_step for 10 cycles, then hold it high for 20 cycles → exactly one en_out pulse. Separately, assert RST_N=0 while pending=1 → en_out=0 immediately and no fire after release.

Source files
------------

// File: rtl/tick_strobe_gen.sv
// tick_strobe_gen: programmable prescaler that paces a method-enable strobe
// under an RDY/EN handshake, with a saturating count of dropped ticks.
//
// Ports:
//   CLK          board clock, all state on posedge
//   RST_N        asynchronous active-low reset
//   run          1 = prescaler counts, 0 = frozen
//   div_max      terminal count, tick period = div_max+1 cycles
//   rdy_in       consumer ready (RDY_count_value)
//   btn_step     (TICK_STEP_BTN_EN only) async step pushbutton, active-high
//   en_out       method enable (EN_count_value) = pending & rdy_in
//   tick         registered raw prescaler tick
//   pending      a request is waiting for rdy_in
//   overrun_cnt  saturating count of ticks dropped while pending
//
// Optional feature macro: TICK_STEP_BTN_EN (debounced step button).
module tick_strobe_gen #(
  parameter int DIV_W = 21,
  parameter int OVR_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             run,
  input  logic [DIV_W-1:0] div_max,
  input  logic             rdy_in,
`ifdef TICK_STEP_BTN_EN
  input  logic             btn_step,
`endif
  output logic             en_out,
  output logic             tick,
  output logic             pending,
  output logic [OVR_W-1:0] overrun_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_PEND
  } state_t;

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  state_t           r_state;
  logic             r_pend;
  logic [OVR_W-1:0] r_ovr;

  logic w_term;
  logic w_req;
  logic w_fire;

  // >= rather than == so shrinking div_max below cnt ticks at once
  assign w_term = run && (r_cnt >= div_max);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (run) begin
      if (w_term) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      r_tick <= w_term;
    end else begin
      r_tick <= 1'b0;
    end
  end

`ifdef TICK_STEP_BTN_EN
  logic [1:0] r_sync;
  logic       r_db;
  logic [3:0] r_db_cnt;
  logic       w_db_flip;
  logic       w_step;

  // db follows the synced level only after 16 consecutive differing cycles
  assign w_db_flip = (r_sync[1] != r_db) && (r_db_cnt == 4'd15);
  assign w_step    = w_db_flip && r_sync[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync   <= 2'b00;
      r_db     <= 1'b0;
      r_db_cnt <= 4'd0;
    end else begin
      r_sync <= {r_sync[0], btn_step};
      if (r_sync[1] == r_db) begin
        r_db_cnt <= 4'd0;
      end else if (w_db_flip) begin
        r_db     <= r_sync[1];
        r_db_cnt <= 4'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 4'd1;
      end
    end
  end

  // a step coinciding with a tick is one request
  assign w_req = w_term | w_step;
`else
  assign w_req = w_term;
`endif

  assign en_out = r_pend & rdy_in;
  assign w_fire = en_out;

  // the request is taken on the same edge that raises tick,
  // so pending and en_out line up with tick
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_ovr   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_PEND;
            r_pend  <= 1'b1;
          end else if (run) begin
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_req) begin
            r_state <= S_PEND;
            r_pend  <= 1'b1;
          end else if (!run) begin
            r_state <= S_IDLE;
          end
        end
        S_PEND: begin
          if (w_fire && !w_req) begin
            r_state <= run ? S_ARMED : S_IDLE;
            r_pend  <= 1'b0;
          end else if (!w_fire && w_req) begin
            if (r_ovr != '1) begin
              r_ovr <= r_ovr + OVR_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  assign tick        = r_tick;
  assign pending     = r_pend;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_tick_strobe_gen.sv
// tb_tick_strobe_gen: scenario tasks plus a randomized run
// against a behavioural model of tick_strobe_gen.
module tb_tick_strobe_gen;

  logic        CLK;
  logic        RST_N;
  logic        run;
  logic [20:0] div_max;
  logic        rdy_in;
  logic        en_out;
  logic        tick;
  logic        pending;
  logic [7:0]  overrun_cnt;
`ifdef TICK_STEP_BTN_EN
  logic        btn_step;
`endif

  int n_run;
  int n_fail;

  tick_strobe_gen #(
    .DIV_W(21),
    .OVR_W(8)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .run        (run),
    .div_max    (div_max),
    .rdy_in     (rdy_in),
`ifdef TICK_STEP_BTN_EN
    .btn_step   (btn_step),
`endif
    .en_out     (en_out),
    .tick       (tick),
    .pending    (pending),
    .overrun_cnt(overrun_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N   = 1'b0;
    run     = 1'b0;
    rdy_in  = 1'b0;
    div_max = '0;
`ifdef TICK_STEP_BTN_EN
    btn_step = 1'b0;
`endif
    #3;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    div_max = 21'd3;
    run = 1'b1;
    cyc();
    cyc();
    RST_N  = 1'b0;
    rdy_in = 1'b1;
    #2;
    n_run += 4;
    if (tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_tick: got %b want 0", tick);
    end
    if (pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pend: got %b want 0", pending);
    end
    if (en_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_en: got %b want 0", en_out);
    end
    if (overrun_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_ovr: got %0d want 0", overrun_cnt);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_period();
    logic e;
    do_reset();
    div_max = 21'd3;
    rdy_in  = 1'b1;
    run     = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      e = (k % 4 == 0);
      n_run += 3;
      if (tick !== e) begin
        n_fail++;
        $display("FAIL per_tick k=%0d: got %b want %b", k, tick, e);
      end
      if (en_out !== e) begin
        n_fail++;
        $display("FAIL per_en k=%0d: got %b want %b", k, en_out, e);
      end
      if (pending !== e) begin
        n_fail++;
        $display("FAIL per_pend k=%0d: got %b want %b", k, pending, e);
      end
    end
    n_run++;
    if (overrun_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL per_ovr: got %0d want 0", overrun_cnt);
    end
  endtask

  task automatic test_div0();
    int fires;
    do_reset();
    div_max = '0;
    rdy_in  = 1'b1;
    run     = 1'b1;
    fires   = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (en_out === 1'b1) fires++;
    end
    n_run++;
    if (fires != 10) begin
      n_fail++;
      $display("FAIL div0_fires: got %0d want 10", fires);
    end
  endtask

  task automatic test_overrun();
    int   eo;
    int   pulses;
    logic ep;
    do_reset();
    div_max = 21'd2;
    run     = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      ep = (k >= 3);
      eo = (k < 3) ? 0 : (k / 3) - 1;
      n_run += 2;
      if (pending !== ep) begin
        n_fail++;
        $display("FAIL ovr_pend k=%0d: got %b want %b", k, pending, ep);
      end
      if (int'(overrun_cnt) != eo) begin
        n_fail++;
        $display("FAIL ovr_cnt k=%0d: got %0d want %0d", k, overrun_cnt, eo);
      end
    end
    run    = 1'b0;
    rdy_in = 1'b1;
    #1;
    pulses = (en_out === 1'b1) ? 1 : 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (en_out === 1'b1) pulses++;
    end
    n_run += 3;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL ovr_release: got %0d pulses want 1", pulses);
    end
    if (pending !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_after: got %b want 0", pending);
    end
    if (overrun_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL ovr_hold: got %0d want 5", overrun_cnt);
    end
  endtask

  task automatic test_saturate();
    int eo;
    do_reset();
    div_max = '0;
    run     = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      cyc();
      eo = (k - 1 > 255) ? 255 : k - 1;
      n_run++;
      if (int'(overrun_cnt) != eo) begin
        n_fail++;
        $display("FAIL sat k=%0d: got %0d want %0d", k, overrun_cnt, eo);
      end
    end
  endtask

  task automatic test_div_change();
    logic e;
    do_reset();
    div_max = 21'd20;
    rdy_in  = 1'b1;
    run     = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      n_run++;
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL chg_pre k=%0d: got %b want 0", k, tick);
      end
    end
    div_max = 21'd4;
    for (int k = 11; k <= 21; k++) begin
      cyc();
      e = (k == 11) || (k == 16) || (k == 21);
      n_run += 2;
      if (tick !== e) begin
        n_fail++;
        $display("FAIL chg_tick k=%0d: got %b want %b", k, tick, e);
      end
      if (en_out !== e) begin
        n_fail++;
        $display("FAIL chg_en k=%0d: got %b want %b", k, en_out, e);
      end
    end
  endtask

  task automatic test_run_stop_pending();
    do_reset();
    div_max = 21'd1;
    run     = 1'b1;
    cyc();
    cyc();
    n_run++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_pend0: got %b want 1", pending);
    end
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_run += 2;
      if (pending !== 1'b1) begin
        n_fail++;
        $display("FAIL stop_hold k=%0d: got %b want 1", k, pending);
      end
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_tick k=%0d: got %b want 0", k, tick);
      end
    end
    rdy_in = 1'b1;
    #1;
    n_run++;
    if (en_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_fire: got %b want 1", en_out);
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_run += 3;
      if (pending !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_clr k=%0d: got %b want 0", k, pending);
      end
      if (en_out !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_en k=%0d: got %b want 0", k, en_out);
      end
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_tk k=%0d: got %b want 0", k, tick);
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    div_max = '0;
    run     = 1'b1;
    cyc();
    n_run++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL rp_pend: got %b want 1", pending);
    end
    #2;
    RST_N  = 1'b0;
    rdy_in = 1'b1;
    run    = 1'b0;
    #1;
    n_run++;
    if (en_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rp_en: got %b want 0", en_out);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_run++;
      if (en_out !== 1'b0) begin
        n_fail++;
        $display("FAIL rp_after k=%0d: got %b want 0", k, en_out);
      end
    end
  endtask

  task automatic test_random();
    int   m_cnt;
    int   m_ovr;
    bit   m_tick;
    bit   m_pend;
    bit   req;
    bit   fire;
    logic me;
    do_reset();
    m_cnt  = 0;
    m_ovr  = 0;
    m_tick = 0;
    m_pend = 0;
    div_max = 21'd3;
    for (int k = 0; k < 600; k++) begin
      run    = ($urandom_range(0, 9) != 0);
      rdy_in = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 15) == 0) begin
        div_max = 21'($urandom_range(0, 6));
      end
      #1;
      me = m_pend & rdy_in;
      n_run += 4;
      if (tick !== m_tick) begin
        n_fail++;
        $display("FAIL rnd_tick k=%0d: got %b want %b", k, tick, m_tick);
      end
      if (pending !== m_pend) begin
        n_fail++;
        $display("FAIL rnd_pend k=%0d: got %b want %b", k, pending, m_pend);
      end
      if (en_out !== me) begin
        n_fail++;
        $display("FAIL rnd_en k=%0d: got %b want %b", k, en_out, me);
      end
      if (int'(overrun_cnt) != m_ovr) begin
        n_fail++;
        $display("FAIL rnd_ovr k=%0d: got %0d want %0d", k, overrun_cnt, m_ovr);
      end
      // a request happens when a running prescaler has reached its limit
      req  = run && (m_cnt >= int'(div_max));
      fire = m_pend && rdy_in;
      if (run) m_cnt = req ? 0 : m_cnt + 1;
      m_tick = req;
      if (m_pend && !fire && req && m_ovr < 255) m_ovr++;
      m_pend = req || (m_pend && !fire);
      cyc();
    end
  endtask

`ifdef TICK_STEP_BTN_EN
  task automatic test_step();
    int pulses;
    do_reset();
    rdy_in = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_step = i[0];
      cyc();
      if (en_out === 1'b1) pulses++;
    end
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (en_out === 1'b1) pulses++;
    end
    btn_step = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (en_out === 1'b1) pulses++;
    end
    n_run += 2;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL step_pulses: got %0d want 1", pulses);
    end
    if (pending !== 1'b0) begin
      n_fail++;
      $display("FAIL step_pend: got %b want 0", pending);
    end
  endtask
`endif

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_period();
    test_div0();
    test_overrun();
    test_saturate();
    test_div_change();
    test_run_stop_pending();
    test_reset_pending();
    test_random();
`ifdef TICK_STEP_BTN_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
